ecc_encoder: RTL

ECC_ENCODER -- requirements
Module: ecc_encoder

---
 rtl/ecc_pkg.sv | 14 +
 rtl/ecc_check_gen.sv | 16 +
 rtl/ecc_encoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC definitions: default widths and the check-field layout used by
// both the encoder and the decoder side.
package ecc_pkg;
    localparam int DATA_W_DEF  = 64;
    localparam int CHECK_W_DEF = 8;
    localparam int CW_W_DEF    = DATA_W_DEF + CHECK_W_DEF;
    localparam int INJ_BIT_W   = 7;

    // Parity sits at check-field bit 0 (codeword bit 64); check bits 71:65 are reserved zero.
    localparam int PARITY_CHK  = 0;
    localparam int PARITY_POS  = DATA_W_DEF + PARITY_CHK;
    localparam int RSVD_LO     = PARITY_POS + 1;
    localparam int RSVD_HI     = CW_W_DEF - 1;
endpackage

// File: rtl/ecc_check_gen.sv
// Combinational check-field generator: even parity of the payload in the
// parity slot, reserved check bits held at zero.
module ecc_check_gen
    import ecc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CHECK_W = CHECK_W_DEF
) (
    input  logic [DATA_W-1:0]  data_i,
    output logic [CHECK_W-1:0] check_o
);
    always_comb begin
        check_o             = '0;
        check_o[PARITY_CHK] = ^data_i;
    end
endmodule

// File: rtl/ecc_encoder.sv
// Two-stage ECC encoder with ready/valid on both sides, single-shot bit-flip
// injection for decoder testing, and saturating hand-off statistics.
module ecc_encoder
    import ecc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CHECK_W = CHECK_W_DEF,
    parameter int CNT_W   = 32
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W+CHECK_W-1:0]   out_data,
    input  logic                        inj_arm,
    input  logic [INJ_BIT_W-1:0]        inj_bit,
    output logic                        inj_pending,
    output logic [CNT_W-1:0]            words_out,
    output logic [CNT_W-1:0]            words_injected
);
    localparam int CW_W = DATA_W + CHECK_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CHECK_W-1:0]   chk_p0;
    logic                 vld_p1_q;
    logic [DATA_W-1:0]    data_p1_q;
    logic [CHECK_W-1:0]   chk_p1_q;
    logic                 vld_p2_q;
    logic                 inj_p2_q;
    logic [CW_W-1:0]      cw_p2_q;
    logic                 inj_pending_q;
    logic [INJ_BIT_W-1:0] inj_bit_q;
    logic [CNT_W-1:0]     words_out_q;
    logic [CNT_W-1:0]     words_inj_q;

    logic                 adv_p1, adv_p2, move_p12, out_hs;
    logic                 inj_active, inj_hit;
    logic [INJ_BIT_W-1:0] inj_bit_eff;
    logic [CW_W-1:0]      cw_p1, flip_mask;

    ecc_check_gen #(.DATA_W(DATA_W), .CHECK_W(CHECK_W)) u_check_gen (
        .data_i  (in_data),
        .check_o (chk_p0)
    );

    assign adv_p2   = !vld_p2_q || out_ready;
    assign adv_p1   = !vld_p1_q || adv_p2;
    assign in_ready = sys_rst_n && adv_p1;
    assign move_p12 = vld_p1_q && adv_p2;
    assign out_hs   = vld_p2_q && out_ready;

    // A same-cycle arm overrides the stored index; out-of-range indices flip nothing.
    assign inj_active  = inj_arm || inj_pending_q;
    assign inj_bit_eff = inj_arm ? inj_bit : inj_bit_q;
    assign inj_hit     = move_p12 && inj_active && (32'(inj_bit_eff) < CW_W);
    assign cw_p1       = {chk_p1_q, data_p1_q};
    assign flip_mask   = inj_hit ? (CW_W'(1) << inj_bit_eff) : '0;

    // S1: payload + check field
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  vld_p1_q <= 1'b0;
        else if (adv_p1) vld_p1_q <= in_valid;
    end

    always_ff @(posedge sys_clk) begin
        if (adv_p1 && in_valid) begin
            data_p1_q <= in_data;
            chk_p1_q  <= chk_p0;
        end
    end

    // S2: codeword + injection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p2_q <= 1'b0;
            inj_p2_q <= 1'b0;
            cw_p2_q  <= '0;
        end else begin
            if (adv_p2) vld_p2_q <= vld_p1_q;
            if (move_p12) begin
                cw_p2_q  <= cw_p1 ^ flip_mask;
                inj_p2_q <= inj_hit;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            inj_pending_q <= 1'b0;
            inj_bit_q     <= '0;
        end else begin
            if (move_p12 && inj_active) inj_pending_q <= 1'b0;
            else if (inj_arm)           inj_pending_q <= 1'b1;
            if (inj_arm) inj_bit_q <= inj_bit;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            words_out_q <= '0;
            words_inj_q <= '0;
        end else if (out_hs) begin
            words_out_q <= sat_inc(words_out_q);
            if (inj_p2_q) words_inj_q <= sat_inc(words_inj_q);
        end
    end

    assign out_valid      = vld_p2_q;
    assign out_data       = cw_p2_q;
    assign inj_pending    = inj_pending_q;
    assign words_out      = words_out_q;
    assign words_injected = words_inj_q;
endmodule
